// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 32-bit single-cycle registered ALU with add/sub flags, logic ops,
//            shifts, signed/unsigned set-less-than and an illegal-opcode flag.
//            Optional macro ALU_MUL_EN enables opcode 1011 as the low 32 bits
//            of the unsigned product A*B.
// Revision : 1.0 - initial release
// ============================================================================
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] operand1,
   input  logic [31:0] operand2,
   input  logic [3:0]  opcode,
   input  logic        in_valid,
   output logic [31:0] result,
   output logic        out_valid,
   output logic        zero,
   output logic        carry,
   output logic        overflow,
   output logic        illegal
);

   localparam logic [3:0] c_op_nop  = 4'b0000;
   localparam logic [3:0] c_op_add  = 4'b0001;
   localparam logic [3:0] c_op_sub  = 4'b0010;
   localparam logic [3:0] c_op_and  = 4'b0011;
   localparam logic [3:0] c_op_or   = 4'b0100;
   localparam logic [3:0] c_op_xor  = 4'b0101;
   localparam logic [3:0] c_op_sll  = 4'b0110;
   localparam logic [3:0] c_op_srl  = 4'b0111;
   localparam logic [3:0] c_op_sra  = 4'b1000;
   localparam logic [3:0] c_op_slt  = 4'b1001;
   localparam logic [3:0] c_op_sltu = 4'b1010;
`ifdef ALU_MUL_EN
   localparam logic [3:0] c_op_mul  = 4'b1011;
`endif

   // 33-bit add/sub so bit 32 gives carry-out and borrow directly
   logic [32:0] w_sum;
   logic [32:0] w_diff;
   logic [4:0]  w_shamt;
   logic [31:0] w_result;
   logic        w_carry;
   logic        w_overflow;
   logic        w_illegal;

   assign w_sum   = {1'b0, operand1} + {1'b0, operand2};
   assign w_diff  = {1'b0, operand1} - {1'b0, operand2};
   assign w_shamt = operand2[4:0];

`ifdef ALU_MUL_EN
   logic [31:0] w_prod;
   assign w_prod = operand1 * operand2;
`endif

   // Combinational operation decode; flags default to 0 for non add/sub ops
   always_comb begin
      w_result   = 32'd0;
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      w_illegal  = 1'b0;
      case (opcode)
         c_op_nop:  w_result = 32'd0;
         c_op_add: begin
            w_result   = w_sum[31:0];
            w_carry    = w_sum[32];
            // Same-sign operands giving a different-sign result
            w_overflow = (operand1[31] == operand2[31]) &&
                         (w_sum[31] != operand1[31]);
         end
         c_op_sub: begin
            w_result   = w_diff[31:0];
            w_carry    = w_diff[32];
            // Opposite-sign operands where result sign differs from A
            w_overflow = (operand1[31] != operand2[31]) &&
                         (w_diff[31] != operand1[31]);
         end
         c_op_and:  w_result = operand1 & operand2;
         c_op_or:   w_result = operand1 | operand2;
         c_op_xor:  w_result = operand1 ^ operand2;
         c_op_sll:  w_result = operand1 << w_shamt;
         c_op_srl:  w_result = operand1 >> w_shamt;
         c_op_sra:  w_result = $unsigned($signed(operand1) >>> w_shamt);
         c_op_slt:  w_result = {31'd0, ($signed(operand1) < $signed(operand2))};
         c_op_sltu: w_result = {31'd0, (operand1 < operand2)};
`ifdef ALU_MUL_EN
         c_op_mul:  w_result = w_prod;
`endif
         default: begin
            w_result  = 32'd0;
            w_illegal = 1'b1;
         end
      endcase
   end

   // Output registers: load on accepted operation, hold otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= 32'd0;
         out_valid <= 1'b0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            result   <= w_result;
            zero     <= (w_result == 32'd0);
            carry    <= w_carry;
            overflow <= w_overflow;
            illegal  <= w_illegal;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu: directed vector table, hold and
//            reset sequences, then randomized traffic against a reference
//            model built from plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] operand1 = '0;
   logic [31:0] operand2 = '0;
   logic [3:0]  opcode = '0;
   logic        in_valid = 1'b0;
   logic [31:0] result;
   logic        out_valid, zero, carry, overflow, illegal;

   int errors = 0;
   int checks = 0;

   alu dut (
      .clk(clk), .rst_n(rst_n), .operand1(operand1), .operand2(operand2),
      .opcode(opcode), .in_valid(in_valid), .result(result),
      .out_valid(out_valid), .zero(zero), .carry(carry),
      .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic        ill;
   } exp_t;

   // Reference model from the arithmetic definition of each opcode
   function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      exp_t e;
      longint sa, sb, t;
      longint unsigned ua, ub, u;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      e = '{res: 32'd0, z: 1'b0, c: 1'b0, v: 1'b0, ill: 1'b0};
      case (op)
         4'd0: e.res = 32'd0;
         4'd1: begin
            u = ua + ub; t = sa + sb;
            e.res = u[31:0];
            e.c = (u > 64'h0000_0000_FFFF_FFFF);
            e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'd2: begin
            u = ua - ub; t = sa - sb;
            e.res = u[31:0];
            e.c = (ua < ub);
            e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
         end
         4'd3: e.res = a & b;
         4'd4: e.res = a | b;
         4'd5: e.res = a ^ b;
         4'd6: begin u = ua << b[4:0]; e.res = u[31:0]; end
         4'd7: e.res = a / (32'd1 << b[4:0]);
         4'd8: begin t = sa >>> b[4:0]; e.res = t[31:0]; end
         4'd9: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd10: e.res = (ua < ub) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
         4'd11: begin u = ua * ub; e.res = u[31:0]; end
`endif
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(string name, logic ov, exp_t e);
      chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
      chk({name, ".result"},    result,              e.res);
      chk({name, ".flags"},     {28'd0, zero, carry, overflow, illegal},
                                {28'd0, e.z, e.c, e.v, e.ill});
   endtask

   // One accepted operation, checked one cycle later, then in_valid dropped
   task automatic do_op(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b, exp_t e);
      @(negedge clk);
      opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      chk_all(name, 1'b1, e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   vec_t tbl [18];
   exp_t held, cur, zeros;

   initial begin
      tbl[0]  = '{4'd1, 32'd50, 32'd10, 32'd60,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{4'd2, 32'd50, 32'd10, 32'd40,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{4'd3, 32'd50, 32'd10, 32'd2,     1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4'd4, 32'd50, 32'd10, 32'd58,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'd5, 32'd50, 32'd10, 32'd56,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'd6, 32'd50, 32'd10, 32'd51200, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'd7, 32'd50, 32'd10, 32'd0,     1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{4'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{4'd2, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{4'd8, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'd9, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{4'd0, 32'h1234_5678, 32'h9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{4'd6, 32'd1, 32'h20, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{4'd7, 32'h8000_0000, 32'h1F, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{4'd2, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef ALU_MUL_EN
      tbl[17] = '{4'd11, 32'd50, 32'd10, 32'd500, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      tbl[17] = '{4'd11, 32'd50, 32'd10, 32'd0,   1'b1, 1'b0, 1'b0, 1'b1};
`endif
      zeros = '{res: 32'd0, z: 1'b0, c: 1'b0, v: 1'b0, ill: 1'b0};

      // Reset state
      #12;
      chk_all("reset", 1'b0, zeros);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table
      foreach (tbl[i]) begin
         cur = '{res: tbl[i].res, z: tbl[i].z, c: tbl[i].c, v: tbl[i].v, ill: tbl[i].ill};
         do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, cur);
      end

      // Illegal opcode, then three idle cycles with wiggling inputs: outputs hold
      held = '{res: 32'd0, z: 1'b1, c: 1'b0, v: 1'b0, ill: 1'b1};
      do_op("illegal", 4'hF, 32'hDEAD_BEEF, 32'h1, held);
      for (int k = 0; k < 3; k++) begin
         opcode = 4'd1; operand1 = $urandom; operand2 = $urandom;
         @(posedge clk); #1;
         chk_all($sformatf("hold%0d", k), 1'b0, held);
         @(negedge clk);
      end

      // Reset asserted mid-cycle after an accepted op: immediate clear
      @(negedge clk);
      opcode = 4'd1; operand1 = 32'd3; operand2 = 32'd4; in_valid = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, zeros);
      // Operation presented while in reset is discarded
      @(posedge clk); #1;
      chk_all("in_rst", 1'b0, zeros);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all("post_rst", 1'b0, zeros);

      // Randomized traffic with random in_valid, back-to-back allowed
      held = zeros;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ra, rb;
         logic        rv;
         @(negedge clk);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'hFFFF_FFFF;
            1: ra = 32'h8000_0000;
            2: rb = ra;
            3: rb = 32'h7FFF_FFFF;
            default: ;
         endcase
         rv = ($urandom_range(0, 3) != 0);
         opcode = 4'($urandom_range(0, 15));
         operand1 = ra; operand2 = rb; in_valid = rv;
         if (rv) held = model(opcode, ra, rb);
         @(posedge clk); #1;
         chk_all($sformatf("rnd%0d_op%0d", n, opcode), rv, held);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
